// File: rtl/dev_bus_router.sv
// Parametrised N-slave router for the Aquila M_DEVICE bus.
// Decodes addr top byte, strobes one slave, returns response or error.
module dev_bus_router #(
  parameter int XLEN = 32,
  parameter int N_DEV = 4,
  parameter logic [8*N_DEV-1:0] DEV_PREFIX =
    {8'hC6, 8'hC4, 8'hC2, 8'hC0},
  parameter int TIMEOUT = 255,
  parameter logic [XLEN-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m_strobe_i,
  input  logic [XLEN-1:0]   m_addr_i,
  input  logic              m_we_i,
  input  logic [XLEN/8-1:0] m_be_i,
  input  logic [XLEN-1:0]   m_din_i,
  output logic [XLEN-1:0]   m_dout_o,
  output logic              m_ready_o,
  output logic [N_DEV-1:0]  s_strobe_o,
  output logic [XLEN-1:0]   s_addr_o,
  output logic              s_we_o,
  output logic [XLEN/8-1:0] s_be_o,
  output logic [XLEN-1:0]   s_din_o,
  input  logic [N_DEV*XLEN-1:0] s_dout_i,
  input  logic [N_DEV-1:0]  s_ready_i,
  output logic              err_o,
  output logic [XLEN-1:0]   err_addr_o
);

  localparam int TW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int IW =
    (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam logic [TW-1:0] TLIM =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [IW-1:0]   idx, hit_idx;
  logic            hit;
  logic            latch, cap, err_set;
  logic            sel_rdy;
  logic [XLEN-1:0] sel_data;

  // Descending scan so the lowest matching index wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (m_addr_i[XLEN-1 -: 8] == DEV_PREFIX[8*i +: 8]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign sel_rdy  = s_ready_i[idx];
  assign sel_data = s_dout_i[XLEN*idx +: XLEN];

  always_comb begin
    state_n = state;
    timer_n = timer;
    latch   = 1'b0;
    cap     = 1'b0;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (m_strobe_i) begin
          latch = 1'b1;
          if (hit) begin
            state_n = ISSUE;
          end else begin
            err_set = 1'b1;
            state_n = RESP;
          end
        end
      end
      ISSUE: begin
        if (sel_rdy) begin
          cap     = 1'b1;
          state_n = RESP;
        end else begin
          timer_n = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (sel_rdy) begin
          cap     = 1'b1;
          state_n = RESP;
        end else begin
          timer_n = timer + 1'b1;
          if (TIMEOUT != 0 && timer == TLIM) begin
            err_set = 1'b1;
            state_n = RESP;
          end
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      timer      <= '0;
      idx        <= '0;
      s_addr_o   <= '0;
      s_we_o     <= 1'b0;
      s_be_o     <= '0;
      s_din_o    <= '0;
      m_dout_o   <= '0;
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      if (latch) begin
        idx      <= hit_idx;
        s_addr_o <= m_addr_i;
        s_we_o   <= m_we_i;
        s_be_o   <= m_be_i;
        s_din_o  <= m_din_i;
      end
      if (cap) begin
        m_dout_o <= sel_data;
      end else if (err_set) begin
        m_dout_o <= ERR_DATA;
      end
      // A miss is flagged before the address lands in s_addr_o
      if (err_set) begin
        err_o      <= 1'b1;
        err_addr_o <= (state == IDLE) ? m_addr_i : s_addr_o;
      end
    end
  end

  assign m_ready_o  = (state == RESP);
  assign s_strobe_o = (state == ISSUE) ?
                      (N_DEV'(1) << idx) : '0;

endmodule

// File: tb/tb_dev_bus_router.sv
// Bench for dev_bus_router: fixed vectors, reset corner,
// and random transactions against a latency/response model.
module tb_dev_bus_router;

  localparam int TO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_strobe;
  logic [31:0]  m_addr;
  logic         m_we;
  logic [3:0]   m_be;
  logic [31:0]  m_din;
  logic [31:0]  m_dout;
  logic         m_ready;
  logic [3:0]   s_strobe;
  logic [31:0]  s_addr;
  logic         s_we;
  logic [3:0]   s_be;
  logic [31:0]  s_din;
  logic [127:0] s_dout;
  logic [3:0]   s_ready;
  logic         err;
  logic [31:0]  err_addr;

  int checks = 0;
  int fails  = 0;
  logic        err_exp;
  logic [31:0] ea_exp;
  logic [7:0]  pfx [4];

  dev_bus_router #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_strobe_i(m_strobe), .m_addr_i(m_addr),
    .m_we_i(m_we), .m_be_i(m_be), .m_din_i(m_din),
    .m_dout_o(m_dout), .m_ready_o(m_ready),
    .s_strobe_o(s_strobe), .s_addr_o(s_addr),
    .s_we_o(s_we), .s_be_o(s_be), .s_din_o(s_din),
    .s_dout_i(s_dout), .s_ready_i(s_ready),
    .err_o(err), .err_addr_o(err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [3:0]  be;
    logic [31:0] din;
    int          d;
    int          idx;
    int          lat;
    logic [31:0] xd;
    logic        xe;
    logic [31:0] xa;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic quiet();
    m_strobe = 1'b0;
    m_addr   = '0;
    m_we     = 1'b0;
    m_be     = '0;
    m_din    = '0;
    s_ready  = '0;
  endtask

  task automatic run_txn(input logic [31:0] a,
                         input logic we,
                         input logic [3:0] be,
                         input logic [31:0] din,
                         input int d, input int idx,
                         input int lat,
                         input logic [31:0] xd,
                         input logic xe,
                         input logic [31:0] xa);
    logic [3:0] oh;
    oh = (idx >= 0) ? 4'(1 << idx) : 4'b0;
    @(posedge clk); #1;
    m_strobe = 1'b1;
    m_addr   = a;
    m_we     = we;
    m_be     = be;
    m_din    = din;
    s_ready  = '0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      chk("s_strobe", 32'(s_strobe),
          (k == 1) ? 32'(oh) : 32'd0);
      chk("m_ready", 32'(m_ready), 32'(k == lat));
      chk("s_addr", s_addr, a);
      chk("s_din", s_din, din);
      chk("s_we_be", 32'({s_we, s_be}), 32'({we, be}));
      if (k == lat) begin
        chk("m_dout", m_dout, xd);
        chk("err", 32'(err), 32'(xe));
        chk("err_addr", err_addr, xa);
        quiet();
      end else begin
        m_strobe = 1'($urandom_range(0, 1));
        m_addr   = $urandom;
        m_we     = 1'($urandom_range(0, 1));
        m_be     = 4'($urandom);
        m_din    = $urandom;
        s_ready  = 4'($urandom);
        if (idx >= 0) s_ready[idx] = (k == d);
      end
    end
  endtask

  task automatic model_txn(input logic [31:0] a,
                           input logic we,
                           input logic [3:0] be,
                           input logic [31:0] din,
                           input int d);
    int idx;
    int lat;
    logic [31:0] xd;
    idx = -1;
    for (int i = 3; i >= 0; i--)
      if (a[31:24] == pfx[i]) idx = i;
    if (idx < 0) begin
      lat = 1; xd = ERR;
      err_exp = 1'b1; ea_exp = a;
    end else if (d <= TO + 1) begin
      lat = d + 1;
      xd  = s_dout[32*idx +: 32];
    end else begin
      lat = TO + 2; xd = ERR;
      err_exp = 1'b1; ea_exp = a;
    end
    run_txn(a, we, be, din, d, idx, lat,
            xd, err_exp, ea_exp);
  endtask

  initial begin
    pfx[0] = 8'hC0; pfx[1] = 8'hC2;
    pfx[2] = 8'hC4; pfx[3] = 8'hC6;
    tbl[0] = '{32'hC000_0004, 1'b0, 4'hF, 32'h0, 1, 0, 2,
               32'h0000_0041, 1'b0, 32'h0};
    tbl[1] = '{32'hC200_0010, 1'b1, 4'hF, 32'h1234_5678,
               3, 1, 4, 32'h1111_0001, 1'b0, 32'h0};
    tbl[2] = '{32'hC500_0000, 1'b0, 4'hF, 32'h0, 0, -1, 1,
               ERR, 1'b1, 32'hC500_0000};
    tbl[3] = '{32'hC600_0000, 1'b0, 4'hF, 32'h0, 99, 3, 6,
               ERR, 1'b1, 32'hC600_0000};
    tbl[4] = '{32'hC000_0008, 1'b0, 4'hF, 32'h0, 1, 0, 2,
               32'h0000_0041, 1'b1, 32'hC600_0000};
    tbl[5] = '{32'hC400_0000, 1'b0, 4'h3, 32'h0, 5, 2, 6,
               32'h2222_0002, 1'b1, 32'hC600_0000};
    tbl[6] = '{32'hC4AB_0000, 1'b1, 4'h1, 32'hAA, 6, 2, 6,
               ERR, 1'b1, 32'hC4AB_0000};
    tbl[7] = '{32'hC100_0000, 1'b0, 4'hF, 32'h0, 0, -1, 1,
               ERR, 1'b1, 32'hC100_0000};
    tbl[8] = '{32'hC2FF_FFFC, 1'b0, 4'hF, 32'h0, 2, 1, 3,
               32'h1111_0001, 1'b1, 32'hC100_0000};

    quiet();
    s_dout = {32'h3333_0003, 32'h2222_0002,
              32'h1111_0001, 32'h0000_0041};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 32'(m_ready), 32'd0);
    chk("rst_strobe", 32'(s_strobe), 32'd0);
    chk("rst_dout", m_dout, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_saddr", s_addr, 32'd0);

    for (int i = 0; i < 9; i++)
      run_txn(tbl[i].a, tbl[i].we, tbl[i].be, tbl[i].din,
              tbl[i].d, tbl[i].idx, tbl[i].lat,
              tbl[i].xd, tbl[i].xe, tbl[i].xa);

    // Reset while slave2 is pending in WAIT
    @(posedge clk); #1;
    m_strobe = 1'b1;
    m_addr   = 32'hC400_0020;
    m_we     = 1'b1;
    m_be     = 4'hF;
    m_din    = 32'h5555_AAAA;
    @(posedge clk); #1;
    quiet();
    @(posedge clk); #1;
    chk("wait_ready", 32'(m_ready), 32'd0);
    chk("wait_strobe", 32'(s_strobe), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_ready", 32'(m_ready), 32'd0);
    chk("rst2_strobe", 32'(s_strobe), 32'd0);
    chk("rst2_dout", m_dout, 32'd0);
    chk("rst2_saddr", s_addr, 32'd0);
    chk("rst2_sdin", s_din, 32'd0);
    chk("rst2_webe", 32'({s_we, s_be}), 32'd0);
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_eaddr", err_addr, 32'd0);
    @(posedge clk); #1;
    chk("rst2_noready", 32'(m_ready), 32'd0);
    err_exp = 1'b0;
    ea_exp  = '0;
    model_txn(32'hC000_0100, 1'b0, 4'hF, 32'h0, 1);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 4);
      a   = $urandom;
      if (sel < 4) begin
        a[31:24] = pfx[sel];
      end else begin
        while (a[31:24] == 8'hC0 || a[31:24] == 8'hC2 ||
               a[31:24] == 8'hC4 || a[31:24] == 8'hC6)
          a[31:24] = 8'($urandom);
      end
      s_dout = {$urandom, $urandom, $urandom, $urandom};
      model_txn(a, 1'($urandom_range(0, 1)), 4'($urandom),
                $urandom, $urandom_range(1, 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
